// File: rtl/sign_extend_imm_pkg.sv
// sign_extend_imm_pkg
//   Shared core constants and the immediate extension helper. The decoder and
//   sign_extend_imm both call ext_imm so every immediate in the core is
//   widened by the same rule.
package sign_extend_imm_pkg;

  // Default core word and immediate field widths.
  localparam int INTEGER_WIDTH_DEF = 32;
  localparam int IMM_WIDTH_DEF     = 19;

  // Widest word ext_imm can produce. Callers keep their own widths at or
  // below this value and slice the result down.
  localparam int EXT_MAX_W = 64;

  typedef logic [EXT_MAX_W-1:0] ext_word_t;

  // Widen the low imm_w bits of raw to EXT_MAX_W bits.
  //   zext = 1 : bits at and above imm_w are 0
  //   zext = 0 : bits at and above imm_w copy raw[imm_w-1]
  // imm_w must be in 1..EXT_MAX_W. Callers check this at elaboration.
  function automatic ext_word_t ext_imm(input ext_word_t raw,
                                        input int        imm_w,
                                        input logic      zext);
    ext_word_t res;
    logic      fill;
    fill = zext ? 1'b0 : raw[imm_w-1];
    for (int i = 0; i < EXT_MAX_W; i++)
      res[i] = (i < imm_w) ? raw[i] : fill;
    return res;
  endfunction

endpackage

// File: rtl/sign_extend_imm.sv
// sign_extend_imm
//   Widens an IMM_WIDTH-bit immediate field to INTEGER_WIDTH bits. There are
//   two copies of the result.
//   - out   : combinational sign extension of in. It does not depend on clk,
//             rst_n, in_valid or zero_ext.
//   - out_q : one-cycle registered copy. It is loaded only when in_valid is
//             high. zero_ext selects a zero fill instead of a sign fill.
// Ports
//   clk        rising-edge clock for the register stage
//   rst_n      asynchronous active-low reset. Clears out_q and out_valid.
//   in         raw immediate field (signed)
//   out        combinational sign-extended immediate (signed)
//   in_valid   qualifies in for the register stage
//   zero_ext   register stage only: 1 = zero-extend, 0 = sign-extend
//   out_q      registered extended immediate
//   out_valid  out_q holds a result captured on the previous edge
module sign_extend_imm
  import sign_extend_imm_pkg::*;
#(
  parameter int IMM_WIDTH     = IMM_WIDTH_DEF,
  parameter int INTEGER_WIDTH = INTEGER_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [IMM_WIDTH-1:0]     in,
  output logic signed [INTEGER_WIDTH-1:0] out,
  input  logic                            in_valid,
  input  logic                            zero_ext,
  output logic        [INTEGER_WIDTH-1:0] out_q,
  output logic                            out_valid
);

  // Reject unusable widths while the design is being elaborated.
  if (IMM_WIDTH < 1 || IMM_WIDTH > INTEGER_WIDTH) begin : g_bad_imm_w
    $fatal(1, "sign_extend_imm: IMM_WIDTH=%0d must be in 1..INTEGER_WIDTH=%0d",
           IMM_WIDTH, INTEGER_WIDTH);
  end
  if (INTEGER_WIDTH > EXT_MAX_W) begin : g_bad_int_w
    $fatal(1, "sign_extend_imm: INTEGER_WIDTH=%0d exceeds %0d",
           INTEGER_WIDTH, EXT_MAX_W);
  end

  // The input is padded with zeros up to the helper's fixed width. Only
  // bits below IMM_WIDTH are read by ext_imm.
  ext_word_t in_wide;
  ext_word_t sext_full;
  ext_word_t rext_full;

  always_comb begin
    in_wide                = '0;
    in_wide[IMM_WIDTH-1:0] = in;
  end

  assign sext_full = ext_imm(in_wide, IMM_WIDTH, 1'b0);
  assign rext_full = ext_imm(in_wide, IMM_WIDTH, zero_ext);

  assign out = sext_full[INTEGER_WIDTH-1:0];

  // Bits above the word width are never used.
  if (INTEGER_WIDTH < EXT_MAX_W) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{sext_full[EXT_MAX_W-1:INTEGER_WIDTH],
                         rext_full[EXT_MAX_W-1:INTEGER_WIDTH]};
  end

  // Register stage: load on in_valid, otherwise hold.
  // out_valid follows in_valid with a one-cycle delay.
  logic [INTEGER_WIDTH-1:0] out_q_d,     out_q_q;
  logic                     out_valid_d, out_valid_q;

  always_comb begin
    out_q_d     = out_q_q;
    out_valid_d = in_valid;
    if (in_valid)
      out_q_d = rext_full[INTEGER_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_q     = out_q_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extend_imm.sv
// tb_sign_extend_imm
//   Testbench for sign_extend_imm at its default widths (32/19). Expected
//   values come from a reference model in plain integer arithmetic. The model
//   reads the field as a two's-complement number, or as unsigned when zero
//   extension is selected, and then truncates the value to 32 bits.
module tb_sign_extend_imm;

  localparam int IW = 19;
  localparam int OW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [IW-1:0] in = '0;
  logic signed [OW-1:0] out;
  logic                 in_valid = 1'b0;
  logic                 zero_ext = 1'b0;
  logic        [OW-1:0] out_q;
  logic                 out_valid;

  int nvec = 0;
  int nerr = 0;

  // Reference copy of the register stage.
  logic [OW-1:0] m_q = '0;
  logic          m_v = 1'b0;

  sign_extend_imm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .out       (out),
    .in_valid  (in_valid),
    .zero_ext  (zero_ext),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OW-1:0] got,
                     input logic [OW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input int unsigned raw, input bit zext);
    longint v;
    v = longint'(raw % (1 << IW));
    if (!zext && v >= (longint'(1) << (IW - 1)))
      v -= (longint'(1) << IW);
    return v[OW-1:0];
  endfunction

  // Drive on a falling edge. Check the combinational output, then the
  // register stage just after the next rising edge.
  task automatic step(input int unsigned raw, input bit v, input bit z);
    @(negedge clk);
    in       = raw[IW-1:0];
    in_valid = v;
    zero_ext = z;
    #1 chk("comb_out", out, model(raw, 1'b0));
    @(posedge clk);
    if (v) m_q = model(raw, z);
    m_v = v;
    #1;
    chk("out_q", out_q, m_q);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_v});
    // A change to zero_ext or in after the edge must not disturb out_q.
    zero_ext = ~z;
    in       = ~in;
    #1 chk("out_q_hold", out_q, m_q);
  endtask

  initial begin
    int unsigned dir [6];
    dir = '{32'd12345, 32'h72BCF, 32'h3FFFF, 32'h40000, 32'h7FFFF, 32'd0};

    // Reset state. The combinational output must be live during reset.
    in = 19'h72BCF;
    #2;
    chk("rst_out_q", out_q, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_comb", out, 32'hFFFF2BCF);
    // A valid input that is sampled while in reset is discarded.
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_discard", out_q, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Directed cases for the combinational output, in the same delta step.
    foreach (dir[i]) begin
      in = dir[i][IW-1:0];
      #1 chk("comb_dir", out, model(dir[i], 1'b0));
    end
    in = 19'h72BCF;
    #1 chk("comb_neg", out, 32'hFFFF2BCF);
    in = 19'h03039;
    #1 chk("comb_pos", out, 32'h00003039);

    // Directed cases for the register stage.
    step(32'h72BCF, 1'b1, 1'b0);
    chk("reg_sext", out_q, 32'hFFFF2BCF);
    step(32'h72BCF, 1'b1, 1'b1);
    chk("reg_zext", out_q, 32'h00072BCF);
    step(32'h12345, 1'b0, 1'b0);
    chk("reg_hold", out_q, 32'h00072BCF);
    chk("reg_hold_v", {31'b0, out_valid}, 32'h0);

    // Random stimulus.
    for (int n = 0; n < 150; n++)
      step($urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

    // Assert reset between edges. The clear must happen at once.
    step(32'h40000, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", out_q, 32'h0);
    chk("mid_rst_v", {31'b0, out_valid}, 32'h0);
    m_q = '0;
    m_v = 1'b0;
    in       = 19'h7FFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_discard", out_q, 32'h0);
    // After release, the first valid input appears one edge later.
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_q", out_q, 32'h0);
    step(32'h3FFFF, 1'b1, 1'b0);
    chk("post_rst_cap", out_q, 32'h0003FFFF);

    for (int n = 0; n < 50; n++)
      step($urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sign_extend_imm.md
SIGN_EXTEND_IMM -- requirements
Module: sign_extend_imm

Interface
REQ-001 The block SHALL have parameter INTEGER_WIDTH, default 32, giving the output word width in bits.
REQ-002 The block SHALL have parameter IMM_WIDTH, default 19, giving the immediate field width in bits; its position SHALL be the first positional parameter.
REQ-003 Port clk  input  1  system clock; all registered state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in  input  IMM_WIDTH (signed)  raw immediate field.
REQ-006 Port out  output  INTEGER_WIDTH (signed)  combinational sign-extended immediate.
REQ-007 Port in_valid  input  1  qualifies in for the registered path.
REQ-008 Port zero_ext  input  1  registered path only: 1 = zero-extend, 0 = sign-extend.
REQ-009 Port out_q  output  INTEGER_WIDTH  registered extended immediate.
REQ-010 Port out_valid  output  1  out_q holds a result captured from a valid input.

Function
REQ-011 out SHALL equal in[IMM_WIDTH-1] replicated into bits INTEGER_WIDTH-1..IMM_WIDTH, concatenated with in[IMM_WIDTH-1:0].
REQ-012 out SHALL be purely combinational: zero latency, no dependence on clk, rst_n, in_valid or zero_ext.
REQ-013 The signed value of out SHALL equal the signed value of in for every IMM_WIDTH-bit input.
REQ-014 When IMM_WIDTH equals INTEGER_WIDTH, out SHALL equal in bit-for-bit.
REQ-015 IMM_WIDTH outside 1..INTEGER_WIDTH SHALL be rejected at elaboration with a fatal message.
REQ-016 On a rising clk with in_valid=1, out_q SHALL load the extension of in (zero-extended if zero_ext=1, else identical to out), and out_valid SHALL become 1.
REQ-017 On a rising clk with in_valid=0, out_q SHALL hold its value and out_valid SHALL become 0.
REQ-018 Registered-path latency SHALL be exactly one clock cycle from the sampled in/in_valid to out_q/out_valid.
REQ-019 zero_ext SHALL be sampled on the same edge as in; a change between edges SHALL not affect out_q.

Reset
REQ-020 rst_n=0 SHALL immediately force out_q to 0 and out_valid to 0, independent of clk.
REQ-021 A valid input sampled while rst_n=0 SHALL be discarded; capture resumes on the first rising edge after rst_n deasserts.
REQ-022 out SHALL remain a valid combinational function of in during reset.

Structure
REQ-023 Default widths (INTEGER_WIDTH=32, IMM_WIDTH=19) SHALL be constants in the shared core package; the extension function SHALL live in that package for reuse by the decoder.
REQ-024 The block SHALL be a single flat module with no sub-modules: one combinational extender and one register stage.

Verification
REQ-025 in=12345 (0x03039) -> out=12345 (0x00003039), same delta step.
REQ-026 in=-54321 (0x72BCF) -> out=-54321 (0xFFFF2BCF).
REQ-027 Boundaries: in=0x3FFFF -> 0x0003FFFF; in=0x40000 -> 0xFFFC0000; in=0x7FFFF -> 0xFFFFFFFF; in=0 -> 0.
REQ-028 Registered path: in=0x72BCF, in_valid=1, zero_ext=0 -> after one edge out_q=0xFFFF2BCF, out_valid=1; repeat with zero_ext=1 -> out_q=0x00072BCF.
REQ-029 in_valid=0 for one edge -> out_q unchanged, out_valid=0.
REQ-030 Assert rst_n=0 mid-stream between edges -> out_q=0 and out_valid=0 immediately; after release the first valid input appears one edge later.
